// File: rtl/press_capture_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// press_capture_pkg - SEQ mode constants and FIFO count sizing
// rev 1.0
// ------------------------------------------------------------------
package press_capture_pkg;

  localparam int MODE_PULSE = 0;
  localparam int MODE_HOLD  = 1;

  // COUNT must be able to represent DEPTH itself, hence the extra bit.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/press_capture_buffer_btn_debounce.sv
`default_nettype none
// ------------------------------------------------------------------
// btn_debounce - 2-flop synchroniser plus stable-run debouncer
// rev 1.0
// ------------------------------------------------------------------
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic rise
);

  localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYC - 1);
  localparam logic [CW-1:0] C_ONE  = CW'(1);

  logic          meta_q, meta_d;
  logic          sync_q, sync_d;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // rise is combinational so the capture lands on the same edge as the flip.
  always_comb begin
    meta_d  = btn;
    sync_d  = meta_q;
    level_d = level_q;
    cnt_d   = '0;
    rise    = 1'b0;
    if (sync_q != level_q) begin
      if (cnt_q == C_LAST) begin
        level_d = sync_q;
        rise    = sync_q;
      end else begin
        cnt_d = cnt_q + C_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      meta_q  <= meta_d;
      sync_q  <= sync_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;

endmodule
`default_nettype wire

// File: rtl/press_capture_buffer.sv
`default_nettype none
// ------------------------------------------------------------------
// press_capture_buffer - debounced LED snapshot with history FIFO
// rev 1.0
// ------------------------------------------------------------------
module press_capture_buffer
  import press_capture_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 4,
  parameter int DEBOUNCE_CYC = 16,
  parameter int HOLD_MODE    = MODE_PULSE
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          btn,
  input  logic [WIDTH-1:0]              leds,
  input  logic                          clr,
  input  logic                          rd_en,
  output logic [WIDTH-1:0]              seq,
  output logic                          cap_vld,
  output logic [WIDTH-1:0]              rd_data,
  output logic                          empty,
  output logic                          full,
  output logic [count_width(DEPTH)-1:0] count,
  output logic                          ovf
);

  localparam int CW = count_width(DEPTH);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] C_DEPTH   = CW'(DEPTH);
  localparam logic [CW-1:0] C_ONE     = CW'(1);
  localparam logic [PW-1:0] C_PTR_ONE = PW'(1);

  logic             rise;
  logic             btn_level_unused;
  logic             cap, push, pop;
  logic [WIDTH-1:0] seq_q, seq_d;
  logic             cap_vld_q, cap_vld_d;
  logic             ovf_q, ovf_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  btn_debounce #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_debounce (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn),
    .level (btn_level_unused),
    .rise  (rise)
  );

  assign empty = (count_q == '0);
  assign full  = (count_q == C_DEPTH);

  // A pop on the capture cycle frees the slot, so a FULL buffer still accepts.
  always_comb begin
    cap       = rise & ~clr;
    pop       = rd_en & ~empty;
    push      = cap & (~full | pop);
    cap_vld_d = cap;
    seq_d     = (HOLD_MODE == MODE_HOLD) ? seq_q : '0;
    if (clr) begin
      seq_d = '0;
    end else if (cap) begin
      seq_d = leds;
    end
    ovf_d    = ovf_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      ovf_d    = 1'b0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (cap & full & ~pop) begin
        ovf_d = 1'b1;
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + C_PTR_ONE;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + C_PTR_ONE;
      end
      if (push & ~pop) begin
        count_d = count_q + C_ONE;
      end else if (pop & ~push) begin
        count_d = count_q - C_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_q     <= '0;
      cap_vld_q <= 1'b0;
      ovf_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      seq_q     <= seq_d;
      cap_vld_q <= cap_vld_d;
      ovf_q     <= ovf_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= leds;
    end
  end

  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];
  assign seq     = seq_q;
  assign cap_vld = cap_vld_q;
  assign count   = count_q;
  assign ovf     = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_press_capture_buffer.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_press_capture_buffer - directed and random checks of both SEQ modes
// rev 1.0
// ------------------------------------------------------------------
module tb_press_capture_buffer;
  import press_capture_pkg::*;

  localparam int W   = 8;
  localparam int D   = 4;
  localparam int DEB = 4;
  localparam int CW  = count_width(D);

  logic          clk = 1'b0;
  logic          rst_n, btn, clr, rd_en;
  logic [W-1:0]  leds;

  logic [W-1:0]  p_seq, p_rd_data, h_seq, h_rd_data;
  logic          p_cap_vld, p_empty, p_full, p_ovf;
  logic          h_cap_vld, h_empty, h_full, h_ovf;
  logic [CW-1:0] p_count, h_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit           m_hist [2];
  bit           m_level;
  int           m_run;
  logic [W-1:0] m_q [$];
  bit           m_ovf;
  bit           m_cap;
  logic [W-1:0] m_seq_p, m_seq_h;

  press_capture_buffer #(
    .WIDTH(W), .DEPTH(D), .DEBOUNCE_CYC(DEB), .HOLD_MODE(MODE_PULSE)
  ) dut_pulse (
    .clk(clk), .rst_n(rst_n), .btn(btn), .leds(leds), .clr(clr), .rd_en(rd_en),
    .seq(p_seq), .cap_vld(p_cap_vld), .rd_data(p_rd_data), .empty(p_empty),
    .full(p_full), .count(p_count), .ovf(p_ovf)
  );

  press_capture_buffer #(
    .WIDTH(W), .DEPTH(D), .DEBOUNCE_CYC(DEB), .HOLD_MODE(MODE_HOLD)
  ) dut_hold (
    .clk(clk), .rst_n(rst_n), .btn(btn), .leds(leds), .clr(clr), .rd_en(rd_en),
    .seq(h_seq), .cap_vld(h_cap_vld), .rd_data(h_rd_data), .empty(h_empty),
    .full(h_full), .count(h_count), .ovf(h_ovf)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hist[0] = 1'b0;
    m_hist[1] = 1'b0;
    m_level   = 1'b0;
    m_run     = 0;
    m_q.delete();
    m_ovf     = 1'b0;
    m_cap     = 1'b0;
    m_seq_p   = '0;
    m_seq_h   = '0;
  endtask

  // One clock edge of the specified behaviour, using the inputs present at that edge.
  task automatic model_edge();
    bit sync_now;
    bit rise;
    rise      = 1'b0;
    sync_now  = m_hist[1];
    m_hist[1] = m_hist[0];
    m_hist[0] = btn;
    if (sync_now != m_level) begin
      m_run++;
      if (m_run == DEB) begin
        m_level = sync_now;
        m_run   = 0;
        rise    = sync_now;
      end
    end else begin
      m_run = 0;
    end
    m_cap = rise && !clr;
    if (clr) begin
      m_q.delete();
      m_ovf = 1'b0;
    end else begin
      if (rd_en && m_q.size() > 0) void'(m_q.pop_front());
      if (m_cap) begin
        if (m_q.size() < D) m_q.push_back(leds);
        else m_ovf = 1'b1;
      end
    end
    m_seq_p = m_cap ? leds : '0;
    if (clr) m_seq_h = '0;
    else if (m_cap) m_seq_h = leds;
  endtask

  task automatic check_all();
    logic [W-1:0] head;
    head = (m_q.size() > 0) ? m_q[0] : '0;
    check_eq("p_seq",     p_seq,     m_seq_p);
    check_eq("h_seq",     h_seq,     m_seq_h);
    check_eq("p_cap_vld", p_cap_vld, m_cap);
    check_eq("h_cap_vld", h_cap_vld, m_cap);
    check_eq("p_rd_data", p_rd_data, head);
    check_eq("h_rd_data", h_rd_data, head);
    check_eq("p_empty",   p_empty,   m_q.size() == 0);
    check_eq("h_empty",   h_empty,   m_q.size() == 0);
    check_eq("p_full",    p_full,    m_q.size() == D);
    check_eq("h_full",    h_full,    m_q.size() == D);
    check_eq("p_count",   p_count,   m_q.size());
    check_eq("h_count",   h_count,   m_q.size());
    check_eq("p_ovf",     p_ovf,     m_ovf);
    check_eq("h_ovf",     h_ovf,     m_ovf);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  // Called just after a step; asserts reset between edges.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    check_eq("rst_empty", p_empty, 1);
    check_eq("rst_count", p_count, 0);
    @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;
  endtask

  task automatic press(input logic [W-1:0] v);
    leds = v;
    btn  = 1'b1;
    repeat (DEB + 3) step();
    btn  = 1'b0;
    repeat (DEB + 3) step();
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  initial begin
    int hold_cnt;
    rst_n = 1'b1;
    btn   = 1'b0;
    clr   = 1'b0;
    rd_en = 1'b0;
    leds  = '0;
    model_reset();
    #1 rst_n = 1'b0;
    #1;
    check_all();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Latency: capture lands on edge DEB+1, visible the cycle after.
    leds = 8'h10;
    btn  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check_eq("lat_cap_vld", p_cap_vld, i == DEB + 1);
      check_eq("lat_seq", p_seq, (i == DEB + 1) ? 8'h10 : 8'h00);
    end
    check_eq("lat_rd_data", p_rd_data, 8'h10);
    check_eq("lat_count", p_count, 1);
    btn = 1'b0;
    repeat (DEB + 3) step();

    // Bounce shorter than the debounce window never captures.
    do_clr();
    for (int i = 0; i < 20; i++) begin
      btn = ((i / 2) % 2) != 0;
      step();
    end
    btn = 1'b0;
    repeat (DEB + 3) step();
    check_eq("bounce_count", p_count, 0);
    check_eq("bounce_seq", p_seq, 0);

    // Hold mode keeps the latest capture until CLR.
    press(8'h01);
    check_eq("hold_first", h_seq, 8'h01);
    press(8'h80);
    check_eq("hold_second", h_seq, 8'h80);
    do_clr();
    check_eq("hold_clr", h_seq, 8'h00);

    // Overflow with no reads, then drain.
    press(8'h01);
    press(8'h02);
    press(8'h04);
    press(8'h08);
    press(8'h10);
    check_eq("ovf_full", p_full, 1);
    check_eq("ovf_flag", p_ovf, 1);
    check_eq("ovf_count", p_count, 4);
    for (int i = 0; i < 4; i++) begin
      check_eq("drain_data", p_rd_data, 8'h01 << i);
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
    end
    check_eq("drain_empty", p_empty, 1);
    check_eq("drain_rd_data", p_rd_data, 0);

    // FULL with a pop on the capture cycle: both happen, no overflow.
    do_clr();
    press(8'h01);
    press(8'h02);
    press(8'h04);
    press(8'h08);
    leds = 8'h40;
    btn  = 1'b1;
    repeat (DEB + 1) step();
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check_eq("fullpop_cap", p_cap_vld, 1);
    check_eq("fullpop_count", p_count, 4);
    check_eq("fullpop_ovf", p_ovf, 0);
    btn = 1'b0;
    repeat (DEB + 3) step();
    for (int i = 0; i < 4; i++) begin
      rd_en = 1'b1;
      if (i == 3) check_eq("fullpop_last", p_rd_data, 8'h40);
      step();
    end
    rd_en = 1'b0;

    // Async reset mid-debounce with two entries held.
    press(8'h01);
    press(8'h02);
    leds = 8'h20;
    btn  = 1'b1;
    repeat (2) step();
    async_reset();
    for (int i = 0; i < 8; i++) begin
      step();
      check_eq("rst_lat_cap_vld", p_cap_vld, i == DEB + 1);
    end
    btn = 1'b0;
    repeat (DEB + 3) step();

    // Random traffic against the model.
    hold_cnt = 0;
    for (int i = 0; i < 2000; i++) begin
      if (hold_cnt == 0) begin
        btn      = $urandom_range(0, 1) != 0;
        hold_cnt = $urandom_range(1, 10);
      end
      hold_cnt--;
      leds  = 8'h01 << $urandom_range(0, 7);
      rd_en = $urandom_range(0, 3) == 0;
      clr   = $urandom_range(0, 40) == 0;
      step();
      if ($urandom_range(0, 400) == 0) async_reset();
    end
    clr   = 1'b0;
    rd_en = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
